csr_unit: RTL and testbench



---
 rtl/csr_unit.sv | 185 ++++++++++++++++++
 tb/tb_csr_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// ============================================================================
// Module   : csr_unit
// Brief    : Machine-mode CSR file with trap/mret stacking, mip sampling,
//            vectored mtvec and 64-bit cycle/instret counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_unit #(
  parameter int          NUM_IRQ     = 16,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          COUNTERS_EN = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [11:0]        csr_addr_i,
  input  logic [1:0]         csr_op_i,
  input  logic [31:0]        csr_wdata_i,
  output logic [31:0]        csr_rdata_o,
  output logic               illegal_o,
  input  logic               trap_i,
  input  logic [31:0]        mcause_i,
  input  logic [31:0]        pc_i,
  input  logic               mret_i,
  input  logic               retire_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [31:0]        trap_vector_o,
  output logic [31:0]        mepc_o,
  output logic [31:0]        mcause_o,
  output logic [31:0]        mie_o,
  output logic [31:0]        mtvec_o,
  output logic               mstatus_mie_o,
  output logic               irq_pending_o
);

  localparam logic [1:0]  c_OP_NONE = 2'b00;
  localparam logic [1:0]  c_OP_RW   = 2'b01;
  localparam logic [1:0]  c_OP_RS   = 2'b10;
  localparam logic [31:0] c_IRQ_MASK =
    32'((64'd1 << (16 + NUM_IRQ)) - (64'd1 << 16));

  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [31:0] r_mie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mip;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;

  logic [31:0] w_mstatus;
  logic [31:0] w_rdata;
  logic        w_mapped;
  logic        w_read_only;
  logic        w_is_counter;
  logic        w_wr_attempt;
  logic        w_illegal;
  logic        w_do_write;
  logic [31:0] w_new;
  logic [31:0] w_irq_ext;
  logic [31:0] w_tvec_base;
  logic        w_wr_cyc_lo;
  logic        w_wr_cyc_hi;
  logic        w_wr_ret_lo;
  logic        w_wr_ret_hi;

  assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
  assign w_irq_ext = 32'(irq_i) << 16;

  always_comb begin
    w_rdata      = 32'd0;
    w_mapped     = 1'b1;
    w_read_only  = 1'b0;
    w_is_counter = 1'b0;
    case (csr_addr_i)
      12'h300: w_rdata = w_mstatus;
      12'h304: w_rdata = r_mie;
      12'h305: w_rdata = r_mtvec;
      12'h340: w_rdata = r_mscratch;
      12'h341: w_rdata = r_mepc;
      12'h342: w_rdata = r_mcause;
      12'h344: begin w_rdata = r_mip; w_read_only = 1'b1; end
      12'hB00: begin w_rdata = r_mcycle[31:0];    w_is_counter = 1'b1; end
      12'hB80: begin w_rdata = r_mcycle[63:32];   w_is_counter = 1'b1; end
      12'hB02: begin w_rdata = r_minstret[31:0];  w_is_counter = 1'b1; end
      12'hB82: begin w_rdata = r_minstret[63:32]; w_is_counter = 1'b1; end
      12'hC00: begin w_rdata = r_mcycle[31:0];    w_is_counter = 1'b1; w_read_only = 1'b1; end
      12'hC80: begin w_rdata = r_mcycle[63:32];   w_is_counter = 1'b1; w_read_only = 1'b1; end
      12'hC02: begin w_rdata = r_minstret[31:0];  w_is_counter = 1'b1; w_read_only = 1'b1; end
      12'hC82: begin w_rdata = r_minstret[63:32]; w_is_counter = 1'b1; w_read_only = 1'b1; end
      default: w_mapped = 1'b0;
    endcase
    // Without counters the whole counter space behaves as unmapped.
    if (w_is_counter && !COUNTERS_EN) begin
      w_mapped = 1'b0;
      w_rdata  = 32'd0;
    end
  end

  assign w_wr_attempt = (csr_op_i == c_OP_RW) ||
                        ((csr_op_i != c_OP_NONE) && (csr_wdata_i != 32'd0));
  assign w_illegal    = (csr_op_i != c_OP_NONE) &&
                        (!w_mapped || (w_read_only && w_wr_attempt));
  assign w_do_write   = w_wr_attempt && !w_illegal && !trap_i && !mret_i;

  always_comb begin
    case (csr_op_i)
      c_OP_RW: w_new = csr_wdata_i;
      c_OP_RS: w_new = w_rdata | csr_wdata_i;
      default: w_new = w_rdata & ~csr_wdata_i;
    endcase
  end

  assign w_wr_cyc_lo = w_do_write && (csr_addr_i == 12'hB00);
  assign w_wr_cyc_hi = w_do_write && (csr_addr_i == 12'hB80);
  assign w_wr_ret_lo = w_do_write && (csr_addr_i == 12'hB02);
  assign w_wr_ret_hi = w_do_write && (csr_addr_i == 12'hB82);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= 32'd0;
      r_mtvec        <= MTVEC_RESET & ~32'h2;
      r_mscratch     <= 32'd0;
      r_mepc         <= 32'd0;
      r_mcause       <= 32'd0;
      r_mip          <= 32'd0;
      r_mcycle       <= 64'd0;
      r_minstret     <= 64'd0;
    end else begin
      r_mip <= w_irq_ext;

      // A write to one half freezes the counter for that cycle, no carry.
      if (w_wr_cyc_lo)      r_mcycle[31:0]  <= w_new;
      else if (w_wr_cyc_hi) r_mcycle[63:32] <= w_new;
      else                  r_mcycle        <= r_mcycle + 64'd1;

      if (w_wr_ret_lo)      r_minstret[31:0]  <= w_new;
      else if (w_wr_ret_hi) r_minstret[63:32] <= w_new;
      else if (retire_i)    r_minstret        <= r_minstret + 64'd1;

      if (trap_i) begin
        r_mepc         <= pc_i & ~32'h3;
        r_mcause       <= mcause_i;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (mret_i) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_do_write) begin
        case (csr_addr_i)
          12'h300: begin
            r_mstatus_mie  <= w_new[3];
            r_mstatus_mpie <= w_new[7];
          end
          12'h304: r_mie      <= w_new & c_IRQ_MASK;
          12'h305: r_mtvec    <= w_new & ~32'h2;
          12'h340: r_mscratch <= w_new;
          12'h341: r_mepc     <= w_new & ~32'h3;
          12'h342: r_mcause   <= w_new;
          default: ;
        endcase
      end
    end
  end

  assign w_tvec_base   = {r_mtvec[31:2], 2'b00};
  assign trap_vector_o = (r_mtvec[0] && mcause_i[31]) ?
                         w_tvec_base + {25'd0, mcause_i[4:0], 2'b00} : w_tvec_base;

  assign csr_rdata_o   = w_rdata;
  assign illegal_o     = w_illegal;
  assign mepc_o        = r_mepc;
  assign mcause_o      = r_mcause;
  assign mie_o         = r_mie;
  assign mtvec_o       = r_mtvec;
  assign mstatus_mie_o = r_mstatus_mie;
  assign irq_pending_o = r_mstatus_mie && |(r_mip & r_mie);

endmodule

`default_nettype wire

// File: tb/tb_csr_unit.sv
// ============================================================================
// Module   : tb_csr_unit
// Brief    : Directed self-checking bench for csr_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [11:0] csr_addr_i;
  logic [1:0]  csr_op_i;
  logic [31:0] csr_wdata_i;
  logic        trap_i;
  logic [31:0] mcause_i;
  logic [31:0] pc_i;
  logic        mret_i;
  logic        retire_i;
  logic [3:0]  irq_i;

  logic [31:0] w_rdata, w_tvec, w_mepc, w_mcause, w_mie, w_mtvec;
  logic        w_illegal, w_smie, w_pend;
  logic [31:0] w_nc_rdata, w_nc_tvec, w_nc_mepc, w_nc_mcause, w_nc_mie, w_nc_mtvec;
  logic        w_nc_illegal, w_nc_smie, w_nc_pend;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  csr_unit #(.NUM_IRQ(4), .MTVEC_RESET(32'h0000_0103), .COUNTERS_EN(1'b1)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .csr_addr_i(csr_addr_i), .csr_op_i(csr_op_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(w_rdata), .illegal_o(w_illegal),
    .trap_i(trap_i), .mcause_i(mcause_i), .pc_i(pc_i), .mret_i(mret_i),
    .retire_i(retire_i), .irq_i(irq_i), .trap_vector_o(w_tvec), .mepc_o(w_mepc),
    .mcause_o(w_mcause), .mie_o(w_mie), .mtvec_o(w_mtvec),
    .mstatus_mie_o(w_smie), .irq_pending_o(w_pend)
  );

  csr_unit #(.NUM_IRQ(4), .MTVEC_RESET(32'h0000_0000), .COUNTERS_EN(1'b0)) u_dut_nc (
    .clk_i(clk_i), .rst_ni(rst_ni), .csr_addr_i(csr_addr_i), .csr_op_i(csr_op_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(w_nc_rdata), .illegal_o(w_nc_illegal),
    .trap_i(trap_i), .mcause_i(mcause_i), .pc_i(pc_i), .mret_i(mret_i),
    .retire_i(retire_i), .irq_i(irq_i), .trap_vector_o(w_nc_tvec), .mepc_o(w_nc_mepc),
    .mcause_o(w_nc_mcause), .mie_o(w_nc_mie), .mtvec_o(w_nc_mtvec),
    .mstatus_mie_o(w_nc_smie), .irq_pending_o(w_nc_pend)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one access, let it settle, then clock it in.
  task automatic access(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    csr_op_i = op; csr_addr_i = addr; csr_wdata_i = wd;
    step();
    csr_op_i = 2'b00; csr_wdata_i = 32'd0;
  endtask

  // Peek a CSR with op none; returns the combinational read.
  task automatic peek(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_op_i = 2'b00; csr_addr_i = addr;
    #1;
    check_eq(tag, w_rdata, exp);
  endtask

  logic [31:0] v_saved;

  initial begin
    rst_ni = 1'b0; csr_addr_i = 12'h0; csr_op_i = 2'b00; csr_wdata_i = 32'd0;
    trap_i = 1'b0; mcause_i = 32'd0; pc_i = 32'd0; mret_i = 1'b0;
    retire_i = 1'b0; irq_i = 4'd0;
    step(); step();

    // Reset state
    check_eq("rst_smie",   {31'd0, w_smie}, 32'd0);
    check_eq("rst_pend",   {31'd0, w_pend}, 32'd0);
    check_eq("rst_mie",    w_mie, 32'd0);
    check_eq("rst_mepc",   w_mepc, 32'd0);
    check_eq("rst_mcause", w_mcause, 32'd0);
    check_eq("rst_mtvec",  w_mtvec, 32'h0000_0101);
    peek("rst_mcycle", 12'hB00, 32'd0);
    rst_ni = 1'b1;
    peek("mcycle_pre", 12'hB00, 32'd0);
    step();
    peek("mcycle_first", 12'hB00, 32'd1);

    // Masked RW of mie
    access(2'b01, 12'h304, 32'hFFFF_FFFF);
    check_eq("mie_mask", w_mie, 32'h000F_0000);
    peek("mtvec_rd",   12'h305, 32'h0000_0101);
    peek("mstatus_rd", 12'h300, 32'h0000_1800);

    // Set / clear
    access(2'b01, 12'h340, 32'hA5A5_0000);
    csr_op_i = 2'b10; csr_addr_i = 12'h340; csr_wdata_i = 32'h0000_00FF;
    #1 check_eq("rs_old", w_rdata, 32'hA5A5_0000);
    step(); csr_op_i = 2'b00; csr_wdata_i = 32'd0;
    peek("rs_val", 12'h340, 32'hA5A5_00FF);
    access(2'b11, 12'h340, 32'hA500_0000);
    peek("rc_val", 12'h340, 32'h00A5_00FF);

    // Trap then mret
    access(2'b01, 12'h300, 32'h0000_0008);
    check_eq("mie_set", {31'd0, w_smie}, 32'd1);
    access(2'b01, 12'h305, 32'h0000_0101);
    mcause_i = 32'h0000_0010;
    #1 check_eq("tvec_sync", w_tvec, 32'h0000_0100);
    trap_i = 1'b1; pc_i = 32'h0000_1237; mcause_i = 32'h8000_0010;
    csr_op_i = 2'b01; csr_addr_i = 12'h340; csr_wdata_i = 32'hDEAD_BEEF;
    #1 check_eq("tvec_vec", w_tvec, 32'h0000_0140);
    step();
    trap_i = 1'b0; csr_op_i = 2'b00; csr_wdata_i = 32'd0;
    check_eq("trap_mepc",   w_mepc, 32'h0000_1234);
    check_eq("trap_mcause", w_mcause, 32'h8000_0010);
    check_eq("trap_smie",   {31'd0, w_smie}, 32'd0);
    peek("trap_mstatus", 12'h300, 32'h0000_1880);
    peek("trap_drop",    12'h340, 32'h00A5_00FF);
    mret_i = 1'b1; step(); mret_i = 1'b0;
    peek("mret_mstatus", 12'h300, 32'h0000_1888);

    // Interrupt path
    check_eq("pend_idle", {31'd0, w_pend}, 32'd0);
    irq_i = 4'b0001;
    #1 check_eq("pend_early", {31'd0, w_pend}, 32'd0);
    step();
    check_eq("pend_set", {31'd0, w_pend}, 32'd1);
    access(2'b11, 12'h300, 32'h0000_0008);
    check_eq("pend_clr", {31'd0, w_pend}, 32'd0);

    // Counters: wrap of mcycle
    access(2'b01, 12'hB00, 32'hFFFF_FFFF);
    access(2'b01, 12'hB80, 32'hFFFF_FFFF);
    peek("cyc_lo_max", 12'hB00, 32'hFFFF_FFFF);
    peek("cyc_hi_max", 12'hB80, 32'hFFFF_FFFF);
    step();
    peek("cyc_lo_wrap", 12'hB00, 32'd0);
    peek("cyc_hi_wrap", 12'hB80, 32'd0);
    peek("cyc_shadow",  12'hC00, 32'd0);

    // minstret
    peek("ret_zero", 12'hB02, 32'd0);
    retire_i = 1'b1; step(); step(); step(); retire_i = 1'b0;
    peek("ret_three",  12'hB02, 32'd3);
    peek("ret_shadow", 12'hC02, 32'd3);
    peek("ret_hi",     12'hB82, 32'd0);
    retire_i = 1'b1;
    access(2'b01, 12'hB02, 32'd100);
    retire_i = 1'b0;
    peek("ret_wr_supp", 12'hB02, 32'd100);

    // Illegal accesses
    csr_op_i = 2'b10; csr_addr_i = 12'h344; csr_wdata_i = 32'd0;
    #1 check_eq("mip_rs0_ill", {31'd0, w_illegal}, 32'd0);
    check_eq("mip_rs0_rd", w_rdata, 32'h0001_0000);
    csr_op_i = 2'b01; csr_wdata_i = 32'h5;
    #1 check_eq("mip_rw_ill", {31'd0, w_illegal}, 32'd1);
    csr_addr_i = 12'hC00;
    #1 check_eq("c00_rw_ill", {31'd0, w_illegal}, 32'd1);
    csr_op_i = 2'b10; csr_addr_i = 12'h7C0; csr_wdata_i = 32'd0;
    #1 check_eq("unmap_ill", {31'd0, w_illegal}, 32'd1);
    check_eq("unmap_rd", w_rdata, 32'd0);
    csr_op_i = 2'b00;
    #1 check_eq("unmap_noop", {31'd0, w_illegal}, 32'd0);
    peek("ret_before", 12'hB02, 32'd100);
    v_saved = w_rdata;
    access(2'b01, 12'hC02, 32'h0000_0007);
    peek("ret_after_ill", 12'hB02, v_saved);
    csr_op_i = 2'b10; csr_addr_i = 12'hB00; csr_wdata_i = 32'd0;
    #1 check_eq("nc_b00_ill", {31'd0, w_nc_illegal}, 32'd1);
    check_eq("nc_b00_rd", w_nc_rdata, 32'd0);
    check_eq("en_b00_ill", {31'd0, w_illegal}, 32'd0);
    csr_addr_i = 12'h340;
    #1 check_eq("nc_340_ill", {31'd0, w_nc_illegal}, 32'd0);
    csr_op_i = 2'b00;

    // Reset overrides a same-cycle trap
    rst_ni = 1'b0; trap_i = 1'b1; pc_i = 32'h0000_4000;
    step();
    trap_i = 1'b0; rst_ni = 1'b1;
    check_eq("rst_wins", w_mepc, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
